top_b_to_bcd: RTL and testbench
===============================

Name: top_b_to_bcd

Overview:
Sequential binary-to-BCD converter using the shift-and-add-3 (double-dabble) algorithm, one input bit per clock.
- A rising edge on `load` captures `binaryNumber` and starts a conversion.
- The packed BCD result is published on `BinaryDecimal` with a one-cycle `enaOut` strobe.
- Sits between binary datapath logic and decimal display/formatting logic.

Parameters:
- binaryNumberWidth, 32, width W of the unsigned binary input (>=1).
- numberOfDigits, 6, number N of BCD digits produced (>=1); result is value modulo 10^N.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- binaryNumber  input  W  unsigned value to convert; sampled only at conversion start.
- load  input  1  start request; rising edge (0->1 between consecutive clk samples) while idle starts a conversion.
- BinaryDecimal  output  [N-1:0][3:0]  packed BCD result, digit [0] least significant; registered; holds its value between conversions.
- enaOut  output  1  one-cycle pulse, high in the cycle `BinaryDecimal` takes a new result.

Behaviour:
- Reset (async, rst=1): state IDLE; `BinaryDecimal`=0; `enaOut`=0; internal shift register, BCD accumulator, bit counter, and `load_q` (previous load) all cleared.
- States: IDLE -> SHIFT -> DONE -> IDLE.
- IDLE: on an edge where load=1 and load_q=0:
  - shift register <= binaryNumber; accumulator <= 0; counter <= W; go to SHIFT.
- SHIFT, each edge:
  - every accumulator digit >=5 gets +3 (4-bit add);
  - then {accumulator, shift register} shifts left by 1, with the shift register MSB entering accumulator bit 0;
  - counter decrements; after the W-th shift go to DONE.
- DONE, one edge: `BinaryDecimal` <= accumulator; `enaOut`=1 for exactly that cycle; go to IDLE.
- Latency: start edge E0; shifts at E1..EW; result and enaOut at E(W+1). Default is 33 clocks from the start edge to `enaOut` high.
- `load` held high for many cycles starts exactly one conversion. A new conversion requires load to return to 0 and rise again.
- A rising edge on `load` during SHIFT/DONE is ignored; it does not queue or restart.
- `binaryNumber` changes after E0 do not affect the running conversion.
- Overflow truncation: bits shifted out of the top digit are discarded. Lower N digits are exact (value mod 10^N).
- enaOut is registered, with no combinational path from inputs.
- Reset asserted mid-conversion aborts immediately to the reset values.

Optional Feature:
- Macro OVERFLOW_FLAG_EN.
- Defined: adds output `overflow` (1 bit, registered, reset 0).
  - A sticky internal bit is set if any 1 is shifted out of digit N-1 during SHIFT; it is cleared at start.
  - `overflow` updates together with `BinaryDecimal` in DONE and means value >= 10^N.
- Not defined: no `overflow` port; truncation behaviour identical.

Decomposition:
- Package top_b_to_bcd_pkg:
  - state enum {IDLE, SHIFT, DONE};
  - bcd_digit_t (logic [3:0]);
  - constants ADJ_THRESHOLD=5 and ADJ_VALUE=3.
- Sub-module bcd_digit_adjust: combinational; 4-bit digit in, digit+3 out if >=5, else unchanged; instantiated N times via generate.

Test Plan:
- Default params, binaryNumber=0x552D6 (348886), load high 2 cycles -> after 33 clocks enaOut pulses one cycle; BinaryDecimal digits [5..0]=3,4,8,8,8,6.
- Same value, load held high 6 cycles, then again after 10000 ns -> exactly one enaOut per rising edge; result unchanged (348886).
- binaryNumber=0 -> all digits 0, enaOut pulse. binaryNumber=999999 -> 9,9,9,9,9,9; overflow=0 if OVERFLOW_FLAG_EN is defined.
- binaryNumber=1000000 and 0xFFFFFFFF -> 0,0,0,0,0,0 and 9,6,7,2,9,5 (low 6 digits of 4294967295); overflow=1 with the macro.
- rst pulsed mid-SHIFT -> outputs 0 at once, no enaOut; next load edge converts correctly. binaryNumber changed mid-conversion -> result reflects the captured value.
- W=8, N=3, binaryNumber=255 -> 2,5,5 with enaOut 9 clocks after start.

Source files
------------

// File: rtl/top_b_to_bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
package top_b_to_bcd_pkg;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  typedef logic [3:0] bcd_digit_t;

  localparam bcd_digit_t ADJ_THRESHOLD = 4'd5;
  localparam bcd_digit_t ADJ_VALUE     = 4'd3;

endpackage

// File: rtl/bcd_digit_adjust.sv
// Double-dabble digit correction: adds 3 to a BCD digit of 5 or more so the
// following left shift carries correctly into the next decimal digit.
module bcd_digit_adjust
  import top_b_to_bcd_pkg::*;
(
  input  bcd_digit_t digit,
  output bcd_digit_t adjusted
);

  assign adjusted = (digit >= ADJ_THRESHOLD) ? digit + ADJ_VALUE : digit;

endmodule

// File: rtl/top_b_to_bcd.sv
// Sequential binary-to-BCD (shift-and-add-3), one bit per clock, W+1 clocks from start to result.
// No backpressure: a load edge while busy is dropped. Macro OVERFLOW_FLAG_EN adds the overflow output.
module top_b_to_bcd
  import top_b_to_bcd_pkg::*;
#(
  parameter int binaryNumberWidth = 32,
  parameter int numberOfDigits    = 6
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [binaryNumberWidth-1:0]        binaryNumber,
  input  logic                                load,
  output logic [numberOfDigits-1:0][3:0]      BinaryDecimal,
  output logic                                enaOut
`ifdef OVERFLOW_FLAG_EN
  ,
  output logic                                overflow
`endif
);

  localparam int W  = binaryNumberWidth;
  localparam int N  = numberOfDigits;
  localparam int CW = $clog2(W + 1);

  state_t               state;
  logic [W-1:0]         shift_reg;
  bcd_digit_t [N-1:0]   acc;
  bcd_digit_t [N-1:0]   adj;
  logic [CW-1:0]        bit_cnt;
  logic                 load_q;
  logic [4*N+W-1:0]     shifted;
`ifdef OVERFLOW_FLAG_EN
  logic                 ovf_sticky;
`endif

  for (genvar gi = 0; gi < N; gi++) begin : g_adj
    bcd_digit_adjust u_adj (
      .digit    (acc[gi]),
      .adjusted (adj[gi])
    );
  end

  // The MSB of the top digit falls off the end here: value is kept modulo 10^N.
  assign shifted = {adj, shift_reg} << 1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      shift_reg     <= '0;
      acc           <= '0;
      bit_cnt       <= '0;
      load_q        <= 1'b0;
      BinaryDecimal <= '0;
      enaOut        <= 1'b0;
`ifdef OVERFLOW_FLAG_EN
      ovf_sticky    <= 1'b0;
      overflow      <= 1'b0;
`endif
    end else begin
      load_q <= load;
      enaOut <= 1'b0;
      case (state)
        IDLE: begin
          if (load && !load_q) begin
            shift_reg  <= binaryNumber;
            acc        <= '0;
            bit_cnt    <= CW'(W);
`ifdef OVERFLOW_FLAG_EN
            ovf_sticky <= 1'b0;
`endif
            state      <= SHIFT;
          end
        end
        SHIFT: begin
          {acc, shift_reg} <= shifted;
          bit_cnt          <= bit_cnt - CW'(1);
`ifdef OVERFLOW_FLAG_EN
          if (adj[N-1][3]) ovf_sticky <= 1'b1;
`endif
          if (bit_cnt == CW'(1)) state <= DONE;
        end
        DONE: begin
          BinaryDecimal <= acc;
          enaOut        <= 1'b1;
`ifdef OVERFLOW_FLAG_EN
          overflow      <= ovf_sticky;
`endif
          state         <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_top_b_to_bcd.sv
// Directed + randomized bench for top_b_to_bcd at default (32/6) and small (8/3) sizes.
module tb_top_b_to_bcd;

  logic               clk = 1'b0;
  logic               rst;
  logic [31:0]        bin;
  logic               load;
  logic [5:0][3:0]    bcd;
  logic               ena;
  logic [7:0]         bin8;
  logic               load8;
  logic [2:0][3:0]    bcd8;
  logic               ena8;
`ifdef OVERFLOW_FLAG_EN
  logic               ovf;
  logic               ovf8;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  top_b_to_bcd dut (
    .clk           (clk),
    .rst           (rst),
    .binaryNumber  (bin),
    .load          (load),
    .BinaryDecimal (bcd),
    .enaOut        (ena)
`ifdef OVERFLOW_FLAG_EN
    , .overflow    (ovf)
`endif
  );

  top_b_to_bcd #(.binaryNumberWidth(8), .numberOfDigits(3)) dut8 (
    .clk           (clk),
    .rst           (rst),
    .binaryNumber  (bin8),
    .load          (load8),
    .BinaryDecimal (bcd8),
    .enaOut        (ena8)
`ifdef OVERFLOW_FLAG_EN
    , .overflow    (ovf8)
`endif
  );

  // Reference: decimal digits of (v mod 10^nd), computed arithmetically.
  function automatic logic [23:0] ref_bcd(input longint unsigned v, input int nd);
    logic [23:0] r;
    longint unsigned m;
    r = '0;
    m = 1;
    for (int i = 0; i < nd; i++) m = m * 10;
    v = v % m;
    for (int i = 0; i < nd; i++) begin
      r[i*4 +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One conversion on the 32/6 instance. load held for `hold` cycles; optional
  // second load pulse at reload_k (busy, must be ignored); optional input scramble.
  task automatic conv(input logic [31:0] val, input int hold, input int reload_k,
                      input bit mutate, input string tag);
    int pulses;
    int lat;
    pulses = 0;
    lat = -1;
    @(negedge clk);
    bin  = val;
    load = 1'b1;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (k == hold) load = 1'b0;
      if (k == reload_k) load = 1'b1;
      if (k == reload_k + 2) load = 1'b0;
      if (mutate && k == 3) bin = $urandom;
      if (ena) begin
        pulses++;
        if (lat < 0) lat = k - 1;
      end
    end
    load = 1'b0;
    check({tag, "_lat"}, 64'(lat), 64'd33);
    check({tag, "_pulses"}, 64'(pulses), 64'd1);
    check({tag, "_bcd"}, 64'(bcd), 64'(ref_bcd(64'(val), 6)));
`ifdef OVERFLOW_FLAG_EN
    check({tag, "_ovf"}, 64'(ovf), 64'(val >= 32'd1000000));
`endif
  endtask

  task automatic conv8(input logic [7:0] val, input string tag);
    int pulses;
    int lat;
    pulses = 0;
    lat = -1;
    @(negedge clk);
    bin8  = val;
    load8 = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (k == 2) load8 = 1'b0;
      if (ena8) begin
        pulses++;
        if (lat < 0) lat = k - 1;
      end
    end
    check({tag, "_lat"}, 64'(lat), 64'd9);
    check({tag, "_pulses"}, 64'(pulses), 64'd1);
    check({tag, "_bcd"}, 64'(bcd8), 64'(ref_bcd(64'(val), 3)));
`ifdef OVERFLOW_FLAG_EN
    check({tag, "_ovf"}, 64'(ovf8), 64'd0);
`endif
  endtask

  initial begin
    int pulses;
    logic [31:0] v;
    rst   = 1'b1;
    bin   = '0;
    load  = 1'b0;
    bin8  = '0;
    load8 = 1'b0;
    #1;
    check("reset_bcd", 64'(bcd), 64'd0);
    check("reset_ena", 64'(ena), 64'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;

    conv(32'h000552D6, 2, 0, 1'b0, "basic");
    check("basic_literal", 64'(bcd), 64'h348886);
    conv(32'h000552D6, 6, 0, 1'b0, "hold6");
    #10000;
    conv(32'h000552D6, 40, 0, 1'b0, "hold40");
    conv(32'd0, 1, 0, 1'b0, "zero");
    conv(32'd999999, 1, 0, 1'b0, "max6");
    conv(32'd1000000, 1, 0, 1'b0, "wrap");
    conv(32'hFFFFFFFF, 1, 0, 1'b0, "allones");
    check("allones_literal", 64'(bcd), 64'h967295);
    conv(32'd123456, 2, 10, 1'b1, "busy_reload");

    // Reset mid-SHIFT: outputs clear at once, the aborted conversion never completes.
    @(negedge clk);
    bin  = 32'd654321;
    load = 1'b1;
    repeat (2) @(negedge clk);
    load = 1'b0;
    repeat (8) @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_bcd", 64'(bcd), 64'd0);
    check("midrst_ena", 64'(ena), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    pulses = 0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (ena) pulses++;
    end
    check("midrst_nopulse", 64'(pulses), 64'd0);
    conv(32'd654321, 2, 0, 1'b0, "after_rst");

    for (int i = 0; i < 6; i++) begin
      v = (i % 2 == 0) ? $urandom : 32'($urandom_range(0, 999999));
      conv(v, 1 + (i % 3), 0, 1'b0, $sformatf("rand%0d", i));
    end

    conv8(8'd255, "w8_255");
    conv8(8'd0, "w8_0");
    for (int i = 0; i < 4; i++) conv8(8'($urandom), $sformatf("w8_rand%0d", i));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
